// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM stage: datapath width, FSM encoding and the
// MEM/WB pipeline bundle.
package mem_stage_ctrl_pkg;

  localparam int WIDTH = 32;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] readdata;
    logic [4:0]       regaddr;
  } wb_bundle_t;

  function automatic logic is_word_aligned(input logic [WIDTH-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus. The MEM stage is the master; the memory is the slave.
interface mem_stage_ctrl_if;

  logic                                 req;
  logic                                 we;
  logic [mem_stage_ctrl_pkg::WIDTH-1:0] addr;
  logic [mem_stage_ctrl_pkg::WIDTH-1:0] wdata;
  logic [mem_stage_ctrl_pkg::WIDTH-1:0] rdata;
  logic                                 ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_stage_ctrl_mem2wb_reg.sv
// MEM/WB pipeline register. A bubble loads an all-zero (no-op) bundle.
module mem2wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble_i,
  input  wb_bundle_t wb_d_i,
  output wb_bundle_t wb_q_o
);

  wb_bundle_t wb_q;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // is not in the sensitivity list; state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (bubble_i) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d_i;
    end
  end

  assign wb_q_o = wb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues loads/stores on the dmem bus with a timeout,
// stalls upstream while an access is outstanding, and feeds MEM/WB.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   regwrite_mem,
  input  logic                   memtoreg_mem,
  input  logic                   memwrite_mem,
  input  logic [WIDTH-1:0]       aluout_mem,
  input  logic [WIDTH-1:0]       writedata_mem,
  input  logic [4:0]             regaddr_mem,
  mem_stage_ctrl_if.master       dmem,
  output logic                   stall_mem,
  output logic                   regwrite_wb,
  output logic                   memtoreg_wb,
  output logic [WIDTH-1:0]       aluout_wb,
  output logic [WIDTH-1:0]       readdata_wb,
  output logic [4:0]             regaddr_wb,
  output logic                   misalign_err,
  output logic                   bus_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             req_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             misalign_q;
  logic             bus_err_q;

  logic       memop;
  logic       aligned;
  logic       cnt_last;
  logic       wb_bubble;
  wb_bundle_t wb_d;
  wb_bundle_t wb_q;

  assign memop    = memtoreg_mem | memwrite_mem;
  assign aligned  = is_word_aligned(aluout_mem);
  assign cnt_last = (cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stall_mem = 1'b0;
    wb_bubble = 1'b0;
    wb_d      = '{regwrite: regwrite_mem, memtoreg: memtoreg_mem,
                  aluout: aluout_mem, readdata: '0, regaddr: regaddr_mem};
    unique case (state_q)
      MEM_IDLE: begin
        if (memop && aligned) begin
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
        end else if (memop) begin
          wb_d.regwrite = 1'b0;
        end
      end
      MEM_BUSY: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem.ack) begin
          if (memtoreg_mem) wb_d.readdata = dmem.rdata;
        end else if (cnt_last) begin
          wb_d.regwrite = 1'b0;
        end else begin
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        MEM_IDLE: begin
          misalign_q <= memop && !aligned;
          bus_err_q  <= 1'b0;
          if (memop && aligned) begin
            state_q <= MEM_BUSY;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= memwrite_mem;
            addr_q  <= aluout_mem;
            wdata_q <= writedata_mem;
          end
        end
        MEM_BUSY: begin
          misalign_q <= 1'b0;
          if (dmem.ack || cnt_last) begin
            state_q   <= MEM_IDLE;
            req_q     <= 1'b0;
            bus_err_q <= !dmem.ack;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            bus_err_q <= 1'b0;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  mem2wb_reg u_mem2wb_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (wb_bubble),
    .wb_d_i   (wb_d),
    .wb_q_o   (wb_q)
  );

  assign dmem.req     = req_q;
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = wdata_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;
  assign regwrite_wb  = wb_q.regwrite;
  assign memtoreg_wb  = wb_q.memtoreg;
  assign aluout_wb    = wb_q.aluout;
  assign readdata_wb  = wb_q.readdata;
  assign regaddr_wb   = wb_q.regaddr;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, loads/stores with
// varying ack latency, misalignment, timeout and reset during an access.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             regwrite_mem, memtoreg_mem, memwrite_mem;
  logic [WIDTH-1:0] aluout_mem, writedata_mem;
  logic [4:0]       regaddr_mem;
  logic             stall_mem, regwrite_wb, memtoreg_wb, misalign_err, bus_err;
  logic [WIDTH-1:0] aluout_wb, readdata_wb;
  logic [4:0]       regaddr_wb;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .regwrite_mem  (regwrite_mem),
    .memtoreg_mem  (memtoreg_mem),
    .memwrite_mem  (memwrite_mem),
    .aluout_mem    (aluout_mem),
    .writedata_mem (writedata_mem),
    .regaddr_mem   (regaddr_mem),
    .dmem          (bus),
    .stall_mem     (stall_mem),
    .regwrite_wb   (regwrite_wb),
    .memtoreg_wb   (memtoreg_wb),
    .aluout_wb     (aluout_wb),
    .readdata_wb   (readdata_wb),
    .regaddr_wb    (regaddr_wb),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rw, input logic mtr, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] ra);
    regwrite_mem  = rw;
    memtoreg_mem  = mtr;
    memwrite_mem  = mw;
    aluout_mem    = alu;
    writedata_mem = wd;
    regaddr_mem   = ra;
  endtask

  // Runs one memop from IDLE; the memory acks ack_lat cycles after req rises
  // (negative = never). Returns the number of stalled cycles and the first
  // request seen on the bus.
  task automatic run_access(input int ack_lat, input logic [31:0] rd,
                            output int stalls, output logic seen_we,
                            output logic [31:0] seen_addr, output logic [31:0] seen_wdata);
    int k;
    bit done;
    stalls = 0; k = 0; done = 1'b0;
    seen_we = 1'b0; seen_addr = '0; seen_wdata = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.req) begin
        if (k == 0) begin
          seen_we    = bus.we;
          seen_addr  = bus.addr;
          seen_wdata = bus.wdata;
        end
        if (k == ack_lat) begin
          bus.ack   = 1'b1;
          bus.rdata = rd;
        end
        k++;
      end
      #1;
      if (stall_mem) stalls++;
      else done = 1'b1;
      tick();
      bus.ack   = 1'b0;
      bus.rdata = '0;
    end
    if (!done) check("access_bound", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;

    // Reset with a stray ack on the bus.
    rst = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0);
    bus.ack   = 1'b1;
    bus.rdata = 32'hFFFF_FFFF;
    repeat (2) tick();
    check("rst_req",      bus.req,      1'b0);
    check("rst_we",       bus.we,       1'b0);
    check("rst_addr",     bus.addr,     32'h0);
    check("rst_wdata",    bus.wdata,    32'h0);
    check("rst_regwrite", regwrite_wb,  1'b0);
    check("rst_memtoreg", memtoreg_wb,  1'b0);
    check("rst_aluout",   aluout_wb,    32'h0);
    check("rst_readdata", readdata_wb,  32'h0);
    check("rst_regaddr",  regaddr_wb,   5'd0);
    check("rst_misalign", misalign_err, 1'b0);
    check("rst_buserr",   bus_err,      1'b0);
    check("rst_stall",    stall_mem,    1'b0);
    rst = 1'b1;
    tick();
    check("idle_ack_ignored", bus.req, 1'b0);
    bus.ack   = 1'b0;
    bus.rdata = '0;

    // ALU op: one-cycle pass-through, no request.
    set_instr(1, 0, 0, 32'h1234, 0, 5);
    #1 check("alu_stall", stall_mem, 1'b0);
    tick();
    check("alu_regwrite", regwrite_wb, 1'b1);
    check("alu_aluout",   aluout_wb,   32'h1234);
    check("alu_regaddr",  regaddr_wb,  5'd5);
    check("alu_readdata", readdata_wb, 32'h0);
    check("alu_req",      bus.req,     1'b0);

    // Load, ack three cycles after req.
    set_instr(1, 1, 0, 32'h40, 0, 7);
    run_access(3, 32'hDEAD_BEEF, stalls, s_we, s_addr, s_wdata);
    check("ld_stalls",   stalls,      32'd4);
    check("ld_we",       s_we,        1'b0);
    check("ld_addr",     s_addr,      32'h40);
    check("ld_readdata", readdata_wb, 32'hDEAD_BEEF);
    check("ld_memtoreg", memtoreg_wb, 1'b1);
    check("ld_regwrite", regwrite_wb, 1'b1);
    check("ld_regaddr",  regaddr_wb,  5'd7);
    check("ld_req_drop", bus.req,     1'b0);

    // Store followed directly by a load, ack latency 1.
    set_instr(0, 0, 1, 32'h80, 32'hA5A5_A5A5, 0);
    run_access(1, 32'h1111_2222, stalls, s_we, s_addr, s_wdata);
    check("st_stalls",   stalls,      32'd2);
    check("st_we",       s_we,        1'b1);
    check("st_addr",     s_addr,      32'h80);
    check("st_wdata",    s_wdata,     32'hA5A5_A5A5);
    check("st_readdata", readdata_wb, 32'h0);
    check("st_regwrite", regwrite_wb, 1'b0);
    check("st_req_gap",  bus.req,     1'b0);
    set_instr(1, 1, 0, 32'h84, 0, 9);
    run_access(1, 32'h0BAD_F00D, stalls, s_we, s_addr, s_wdata);
    check("ld2_stalls",   stalls,      32'd2);
    check("ld2_we",       s_we,        1'b0);
    check("ld2_addr",     s_addr,      32'h84);
    check("ld2_readdata", readdata_wb, 32'h0BAD_F00D);
    check("ld2_regaddr",  regaddr_wb,  5'd9);

    // Misaligned load.
    set_instr(1, 1, 0, 32'h42, 0, 3);
    #1 check("mis_stall", stall_mem, 1'b0);
    tick();
    check("mis_err",      misalign_err, 1'b1);
    check("mis_regwrite", regwrite_wb,  1'b0);
    check("mis_aluout",   aluout_wb,    32'h42);
    check("mis_req",      bus.req,      1'b0);
    set_instr(0, 0, 0, 0, 0, 0);
    tick();
    check("mis_pulse_end", misalign_err, 1'b0);

    // Timeout: no ack at all, then a late ack.
    set_instr(1, 1, 0, 32'h100, 0, 4);
    run_access(-1, 32'h0, stalls, s_we, s_addr, s_wdata);
    check("to_stalls",   stalls,      32'd16);
    check("to_buserr",   bus_err,     1'b1);
    check("to_regwrite", regwrite_wb, 1'b0);
    check("to_req_drop", bus.req,     1'b0);
    set_instr(0, 0, 0, 0, 0, 0);
    bus.ack   = 1'b1;
    bus.rdata = 32'h77;
    tick();
    bus.ack   = 1'b0;
    bus.rdata = '0;
    check("to_pulse_end", bus_err,     1'b0);
    check("late_ack_req", bus.req,     1'b0);
    check("late_ack_rd",  readdata_wb, 32'h0);

    // Ack in the very cycle the timeout would fire: ack wins.
    set_instr(1, 1, 0, 32'h200, 0, 6);
    run_access(TIMEOUT - 1, 32'hCAFE_0001, stalls, s_we, s_addr, s_wdata);
    check("edge_stalls",   stalls,      32'd16);
    check("edge_buserr",   bus_err,     1'b0);
    check("edge_regwrite", regwrite_wb, 1'b1);
    check("edge_readdata", readdata_wb, 32'hCAFE_0001);

    // Reset in the middle of an access, then a late ack.
    set_instr(1, 1, 0, 32'h300, 0, 2);
    tick();
    check("rb_req_up", bus.req, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check("rb_req_drop", bus.req, 1'b0);
    rst = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0);
    bus.ack   = 1'b1;
    bus.rdata = 32'h55;
    #1 check("rb_stall", stall_mem, 1'b0);
    tick();
    bus.ack   = 1'b0;
    bus.rdata = '0;
    check("rb_late_req",      bus.req,     1'b0);
    check("rb_late_readdata", readdata_wb, 32'h0);
    check("rb_late_regwrite", regwrite_wb, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM stage of the 5-stage MIPS pipeline. It consumes the EXE/MEM pipeline register outputs, performs loads and stores through a req/ack data-memory handshake with a timeout, and stalls upstream while an access is outstanding. It also contains the MEM/WB pipeline register that feeds write-back.

Parameters:
WIDTH, `WIDTH (32) from defines.v, datapath width.
TIMEOUT, 16, maximum number of cycles in BUSY without dmem_ack before the access is aborted (must be >= 2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
regwrite_mem  in  1  instruction writes the register file
memtoreg_mem  in  1  instruction is a load
memwrite_mem  in  1  instruction is a store
aluout_mem  in  WIDTH  effective address, or ALU result for non-memory ops
writedata_mem  in  WIDTH  store data
regaddr_mem  in  5  destination register
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, registered
dmem_addr  out  WIDTH  word-aligned address, registered
dmem_wdata  out  WIDTH  store data, registered
dmem_rdata  in  WIDTH  load data, valid with dmem_ack
dmem_ack  in  1  access complete, single-cycle pulse
stall_mem  out  1  combinational; upstream stages and the EXE/MEM register must hold while it is high
regwrite_wb  out  1  MEM/WB register: register-file write enable
memtoreg_wb  out  1  MEM/WB register: select load data
aluout_wb  out  WIDTH  MEM/WB register: ALU result
readdata_wb  out  WIDTH  MEM/WB register: load data
regaddr_wb  out  5  MEM/WB register: destination register
misalign_err  out  1  registered one-cycle pulse
bus_err  out  1  registered one-cycle pulse (timeout)

Behaviour:
- Reset: single clock, clk. Reset rst is synchronous and active-low; all state is sampled on the rising clk edge while rst=0. Reset values: state=IDLE, counter=0, and every registered output = 0 (dmem_*, *_wb, misalign_err, bus_err).
- memop = memtoreg_mem | memwrite_mem. aligned = (aluout_mem[1:0] == 2'b00).
- IDLE:
  - Non-memop: stall_mem=0; the MEM/WB register captures the instruction next edge with readdata_wb=0. Latency is 1 cycle.
  - memop and aligned: stall_mem=1; next edge go to BUSY with dmem_req=1, dmem_we=memwrite_mem, dmem_addr=aluout_mem, dmem_wdata=writedata_mem, counter=0. The MEM/WB register captures a bubble (all fields 0).
  - memop and misaligned: stall_mem=0; no request is issued; next edge misalign_err=1 and the instruction enters MEM/WB with regwrite_wb forced to 0.
- BUSY:
  - dmem_req=1 and dmem_addr, dmem_we, dmem_wdata are held stable. Counter increments each cycle.
  - dmem_ack=1: stall_mem=0 that same cycle. Next edge: MEM/WB captures the instruction with readdata_wb=dmem_rdata (0 for stores); state=IDLE; dmem_req=0. Minimum memop latency is 2 cycles.
  - No ack and counter==TIMEOUT-1: stall_mem=0. Next edge: bus_err=1; instruction enters MEM/WB with regwrite_wb=0; state=IDLE; dmem_req=0.
  - Ack and timeout in the same cycle: ack wins, and no bus_err is raised.
  - Otherwise: stall_mem=1 and MEM/WB captures a bubble.
- dmem_ack received while in IDLE is ignored.
- Back-to-back memops: each one re-enters BUSY from IDLE. No request overlap.
- Reset during BUSY: dmem_req drops at that edge; a late ack afterwards is ignored.
- The error pulses last exactly one cycle unless re-triggered.
- The counter is $clog2(TIMEOUT) bits wide and never wraps: it is cleared on entry to BUSY.

Decomposition:
- WIDTH comes from the shared defines.v. FSM state encodings (IDLE=1'b0, BUSY=1'b1) are added to defines.v as MEM_IDLE / MEM_BUSY.
- One sub-module: mem2wb_reg, the MEM/WB register with sync active-low reset and a bubble input (bubble=1 captures all zeros).
- The FSM, counter and dmem interface live in mem_stage_ctrl.

Test Plan:
- Reset: hold rst=0 for 2 cycles with dmem_ack=1 -> all outputs 0, stall_mem=0, state IDLE.
- ALU op: regwrite=1, aluout=0x1234, regaddr=5 -> next cycle regwrite_wb=1, aluout_wb=0x1234, regaddr_wb=5, no dmem_req.
- Load: aluout=0x40, memtoreg=1; memory acks 3 cycles after req with rdata=0xDEADBEEF -> stall_mem high 4 cycles; dmem_addr=0x40, dmem_we=0; then readdata_wb=0xDEADBEEF, memtoreg_wb=1.
- Store then load back-to-back with ack latency 1 -> two separate req phases; dmem_we=1 with wdata=0xA5A5A5A5 for the store, then dmem_we=0; no overlap.
- Misaligned load at 0x42 -> no dmem_req, misalign_err pulse for 1 cycle, regwrite_wb=0, stall_mem=0.
- Timeout: TIMEOUT=16, load with no ack -> stall_mem high 16 cycles, bus_err pulse, regwrite_wb=0; a late ack afterwards is ignored. Also assert rst mid-BUSY -> dmem_req=0 next edge.
